// File: rtl/spatz_vreg_scoreboard.sv
// Issue-side vector-register hazard scoreboard with a one-entry registered dispatch stage.
// Tracks read/write register masks per in-flight id and stalls RAW/WAW/WAR conflicts.
package spatz_vreg_scoreboard_pkg;
  localparam int unsigned NRVREG  = 32;
  localparam int unsigned IdWidth = 5;
  localparam int unsigned NRID    = 2 ** IdWidth;

  typedef logic [IdWidth-1:0] instr_id_t;
  typedef logic [4:0]         vreg_t;

  typedef enum logic [1:0] {CON, VFU, LSU, SLD} ex_unit_e;
  typedef enum logic [2:0] {
    LMUL_1 = 3'd0, LMUL_2 = 3'd1, LMUL_4 = 3'd2, LMUL_8 = 3'd3,
    LMUL_RSVD = 3'd4, LMUL_F8 = 3'd5, LMUL_F4 = 3'd6, LMUL_F2 = 3'd7
  } vlmul_e;

  typedef struct packed {
    vlmul_e vlmul;
  } vtype_t;

  typedef struct packed {
    logic is_load;
  } op_mem_t;

  typedef struct packed {
    instr_id_t id;
    ex_unit_e  ex_unit;
    logic [7:0] op;
    op_mem_t   op_mem;
    vtype_t    vtype;
    vreg_t     vd;
    vreg_t     vs1;
    vreg_t     vs2;
    logic      use_vd;
    logic      use_vs1;
    logic      use_vs2;
    logic      vd_is_src;
  } spatz_req_t;

  typedef struct packed { instr_id_t id; } vfu_rsp_t;
  typedef struct packed { instr_id_t id; } vlsu_rsp_t;
  typedef struct packed { instr_id_t id; } vsldu_rsp_t;
endpackage

module spatz_vreg_scoreboard
  import spatz_vreg_scoreboard_pkg::*;
#(
  parameter int unsigned NrVregs = NRVREG,
  parameter int unsigned NrIds   = NRID
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  spatz_req_t req_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  output spatz_req_t issue_o,
  output logic       issue_valid_o,
  input  logic       issue_ready_i,
  input  vfu_rsp_t   vfu_rsp_i,
  input  logic       vfu_rsp_valid_i,
  input  vlsu_rsp_t  vlsu_rsp_i,
  input  logic       vlsu_rsp_valid_i,
  input  vsldu_rsp_t vsldu_rsp_i,
  input  logic       vsldu_rsp_valid_i,
  output logic       busy_o,
  output logic       hazard_o,
  output logic       retire_err_o
);

  typedef logic [NrVregs-1:0] vmask_t;

  // Aligned group of 2^vlmul registers; fractional and reserved encodings cover one register.
  function automatic vmask_t span(input vreg_t r, input vlmul_e lmul);
    int unsigned n;
    int unsigned base;
    vmask_t      m;
    n    = lmul[2] ? 32'd1 : (32'd1 << lmul[1:0]);
    base = 32'(r) & ~(n - 32'd1);
    m    = '0;
    for (int unsigned i = 0; i < NrVregs; i++) begin
      m[i] = (i >= base) && (i < base + n);
    end
    return m;
  endfunction

  logic [NrIds-1:0] valid_q, valid_d;
  vmask_t           wm_q [NrIds];
  vmask_t           rm_q [NrIds];
  spatz_req_t       issue_q;
  logic             issue_valid_q;
  logic             err_q;

  logic   is_con, is_store, hazard, collision, accept, err_set;
  vmask_t wm, rm, pend_w, pend_r;

  logic      rsp_valid [3];
  instr_id_t rsp_id    [3];

  always_comb begin
    is_con   = (req_i.ex_unit == CON);
    is_store = (req_i.ex_unit == LSU) && !req_i.op_mem.is_load;
    wm       = '0;
    rm       = '0;
    if (!is_con) begin
      if (req_i.use_vd && !is_store)      wm = span(req_i.vd, req_i.vtype.vlmul);
      if (req_i.use_vs1)                  rm = rm | span(req_i.vs1, req_i.vtype.vlmul);
      if (req_i.use_vs2)                  rm = rm | span(req_i.vs2, req_i.vtype.vlmul);
      if (req_i.vd_is_src || is_store)    rm = rm | span(req_i.vd, req_i.vtype.vlmul);
    end
  end

  always_comb begin
    pend_w = '0;
    pend_r = '0;
    for (int unsigned i = 0; i < NrIds; i++) begin
      if (valid_q[i]) begin
        pend_w = pend_w | wm_q[i];
        pend_r = pend_r | rm_q[i];
      end
    end
  end

  always_comb begin
    hazard      = |((rm & pend_w) | (wm & pend_w) | (wm & pend_r));
    collision   = !is_con && valid_q[req_i.id];
    req_ready_o = (!issue_valid_q || issue_ready_i) && !hazard && !collision;
    hazard_o    = req_valid_i && (hazard || collision);
    accept      = req_valid_i && req_ready_o;
  end

  always_comb begin
    rsp_valid[0] = vfu_rsp_valid_i;
    rsp_valid[1] = vlsu_rsp_valid_i;
    rsp_valid[2] = vsldu_rsp_valid_i;
    rsp_id[0]    = vfu_rsp_i.id;
    rsp_id[1]    = vlsu_rsp_i.id;
    rsp_id[2]    = vsldu_rsp_i.id;
    valid_d      = valid_q;
    err_set      = 1'b0;
    // Errors are judged against the pre-cycle table, so duplicate ids clear once silently.
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid[k]) begin
        if (!valid_q[rsp_id[k]]) err_set = 1'b1;
        valid_d[rsp_id[k]] = 1'b0;
      end
    end
    if (accept && !is_con) valid_d[req_i.id] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q       <= '0;
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      err_q         <= 1'b0;
      for (int unsigned i = 0; i < NrIds; i++) begin
        wm_q[i] <= '0;
        rm_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_q | err_set;
      if (accept && !is_con) begin
        wm_q[req_i.id] <= wm;
        rm_q[req_i.id] <= rm;
      end
      if (accept) begin
        issue_q       <= req_i;
        issue_valid_q <= 1'b1;
      end else if (issue_ready_i) begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  assign issue_o       = issue_q;
  assign issue_valid_o = issue_valid_q;
  assign retire_err_o  = err_q;
  assign busy_o        = (|valid_q) || issue_valid_q;

endmodule

// File: tb/tb_spatz_vreg_scoreboard.sv
// Self-checking bench for spatz_vreg_scoreboard: directed scenarios plus randomized traffic
// checked against a set-based model of in-flight instructions.
module tb_spatz_vreg_scoreboard;
  import spatz_vreg_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  spatz_req_t req;
  logic       req_valid, req_ready, issue_valid, issue_ready;
  spatz_req_t issue;
  vfu_rsp_t   vfu_rsp;
  vlsu_rsp_t  vlsu_rsp;
  vsldu_rsp_t vsldu_rsp;
  logic       vfu_v, vlsu_v, vsldu_v, busy, hazard, retire_err;

  always #5 clk = ~clk;

  spatz_vreg_scoreboard dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_i            (req),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .issue_o          (issue),
    .issue_valid_o    (issue_valid),
    .issue_ready_i    (issue_ready),
    .vfu_rsp_i        (vfu_rsp),
    .vfu_rsp_valid_i  (vfu_v),
    .vlsu_rsp_i       (vlsu_rsp),
    .vlsu_rsp_valid_i (vlsu_v),
    .vsldu_rsp_i      (vsldu_rsp),
    .vsldu_rsp_valid_i(vsldu_v),
    .busy_o           (busy),
    .hazard_o         (hazard),
    .retire_err_o     (retire_err)
  );

  typedef struct { int id; bit [31:0] w; bit [31:0] r; } ent_t;
  ent_t       inflight[$];
  bit         m_iv;
  spatz_req_t m_issue;
  bit         m_err;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  function automatic bit [31:0] regs_of(input int r, input int lmul);
    int n;
    int base;
    bit [31:0] s;
    n = (lmul <= 3) ? (2 ** lmul) : 1;
    base = r - (r % n);
    s = '0;
    for (int i = 0; i < n; i++) s[base + i] = 1'b1;
    return s;
  endfunction

  function automatic void model_sets(input spatz_req_t q, output bit [31:0] w, output bit [31:0] r);
    bit st;
    st = (q.ex_unit == LSU) && !q.op_mem.is_load;
    w = '0;
    r = '0;
    if (q.ex_unit == CON) return;
    if (q.use_vd && !st) w = regs_of(int'(q.vd), int'(q.vtype.vlmul));
    if (q.use_vs1) r |= regs_of(int'(q.vs1), int'(q.vtype.vlmul));
    if (q.use_vs2) r |= regs_of(int'(q.vs2), int'(q.vtype.vlmul));
    if (q.vd_is_src || st) r |= regs_of(int'(q.vd), int'(q.vtype.vlmul));
  endfunction

  function automatic bit model_blocked(input spatz_req_t q);
    bit [31:0] w, r, pw, pr;
    if (q.ex_unit == CON) return 1'b0;
    model_sets(q, w, r);
    pw = '0;
    pr = '0;
    foreach (inflight[i]) begin
      if (inflight[i].id == int'(q.id)) return 1'b1;
      pw |= inflight[i].w;
      pr |= inflight[i].r;
    end
    return ((r & pw) | (w & pw) | (w & pr)) != 0;
  endfunction

  function automatic bit model_ready();
    return (!m_iv || issue_ready) && !model_blocked(req);
  endfunction

  function automatic bit is_live(input int id);
    foreach (inflight[i]) if (inflight[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic spatz_req_t mk_req(input int id, input ex_unit_e u, input int vd, input int vs1,
                                        input int vs2, input bit uvd, input bit u1, input bit u2,
                                        input bit vsrc, input bit ld, input int lmul);
    spatz_req_t q;
    q = '0;
    q.id = instr_id_t'(id);
    q.ex_unit = u;
    q.op = 8'($urandom_range(0, 255));
    q.op_mem.is_load = ld;
    q.vtype.vlmul = vlmul_e'(3'(lmul));
    q.vd = vreg_t'(vd);
    q.vs1 = vreg_t'(vs1);
    q.vs2 = vreg_t'(vs2);
    q.use_vd = uvd;
    q.use_vs1 = u1;
    q.use_vs2 = u2;
    q.vd_is_src = vsrc;
    return q;
  endfunction

  // One clock: predict from pre-edge inputs, commit after the edge.
  task automatic tick();
    bit acc;
    int ids[3];
    bit vs[3];
    bit pre[3];
    bit [31:0] w, r;
    spatz_req_t rq;
    bit ir;
    rq = req;
    ir = issue_ready;
    acc = req_valid && model_ready();
    ids[0] = int'(vfu_rsp.id);
    ids[1] = int'(vlsu_rsp.id);
    ids[2] = int'(vsldu_rsp.id);
    vs[0] = vfu_v;
    vs[1] = vlsu_v;
    vs[2] = vsldu_v;
    for (int k = 0; k < 3; k++) pre[k] = is_live(ids[k]);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (vs[k]) begin
        if (!pre[k]) m_err = 1'b1;
        for (int i = 0; i < inflight.size(); i++) begin
          if (inflight[i].id == ids[k]) begin
            inflight.delete(i);
            break;
          end
        end
      end
    end
    if (acc) begin
      if (rq.ex_unit != CON) begin
        model_sets(rq, w, r);
        inflight.push_back('{id: int'(rq.id), w: w, r: r});
      end
      m_iv = 1'b1;
      m_issue = rq;
    end else if (ir) begin
      m_iv = 1'b0;
    end
    #1;
    vfu_v = 1'b0;
    vlsu_v = 1'b0;
    vsldu_v = 1'b0;
  endtask

  task automatic clear_inputs();
    req = '0;
    req_valid = 1'b0;
    issue_ready = 1'b1;
    vfu_rsp = '0;
    vlsu_rsp = '0;
    vsldu_rsp = '0;
    vfu_v = 1'b0;
    vlsu_v = 1'b0;
    vsldu_v = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    inflight.delete();
    m_iv = 1'b0;
    m_issue = '0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    req = mk_req(0, VFU, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    req_valid = 1'b1;
    #1;
    chk_cnt++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid got=%b exp=0", issue_valid); else pass_cnt++;
    chk_cnt++; if (issue !== '0) $display("FAIL rst_issue got=%h exp=0", issue); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (retire_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", retire_err); else pass_cnt++;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", req_ready); else pass_cnt++;
    chk_cnt++; if (hazard !== 1'b0) $display("FAIL rst_hazard got=%b exp=0", hazard); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_reset_midop();
    req = mk_req(0, VFU, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_pre got=%b exp=1", busy); else pass_cnt++;
    rst_ni = 1'b0;
    inflight.delete();
    m_iv = 1'b0;
    #1;
    chk_cnt++; if (issue_valid !== 1'b0) $display("FAIL mid_async_iv got=%b exp=0", issue_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_async_busy got=%b exp=0", busy); else pass_cnt++;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    vfu_rsp.id = 5'd0;
    vfu_v = 1'b1;
    tick();
    chk_cnt++; if (retire_err !== 1'b1) $display("FAIL mid_stale_rsp_err got=%b exp=1", retire_err); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    req = mk_req(0, VFU, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    req_valid = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready0 got=%b exp=1", req_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (issue_valid !== 1'b1) $display("FAIL b2b_iv1 got=%b exp=1", issue_valid); else pass_cnt++;
    chk_cnt++; if (issue.id !== 5'd0) $display("FAIL b2b_id0 got=%0d exp=0", issue.id); else pass_cnt++;
    req = mk_req(1, VFU, 4, 5, 6, 1, 1, 1, 0, 0, 0);
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL b2b_ready1 got=%b exp=1", req_ready); else pass_cnt++;
    tick();
    req_valid = 1'b0;
    #1;
    chk_cnt++; if (issue_valid !== 1'b1) $display("FAIL b2b_iv2 got=%b exp=1", issue_valid); else pass_cnt++;
    chk_cnt++; if (issue !== m_issue) $display("FAIL b2b_issue1 got=%h exp=%h", issue, m_issue); else pass_cnt++;
    tick();
    chk_cnt++; if (issue_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", issue_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_live got=%b exp=1", busy); else pass_cnt++;
    vfu_rsp.id = 5'd0; vfu_v = 1'b1;
    vlsu_rsp.id = 5'd1; vlsu_v = 1'b1;
    tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy_done got=%b exp=0", busy); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_raw();
    req = mk_req(0, VFU, 8, 1, 2, 1, 1, 1, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    req = mk_req(1, VFU, 9, 8, 3, 1, 1, 1, 0, 0, 0);
    #1;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL raw_ready got=%b exp=0", req_ready); else pass_cnt++;
    chk_cnt++; if (hazard !== 1'b1) $display("FAIL raw_hazard got=%b exp=1", hazard); else pass_cnt++;
    tick();
    tick();
    vfu_rsp.id = 5'd0;
    vfu_v = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL raw_no_bypass got=%b exp=0", req_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL raw_after_retire got=%b exp=1", req_ready); else pass_cnt++;
    chk_cnt++; if (hazard !== 1'b0) $display("FAIL raw_hazard_clr got=%b exp=0", hazard); else pass_cnt++;
    tick();
    req_valid = 1'b0;
    #1;
    chk_cnt++; if (issue.id !== 5'd1 || issue_valid !== 1'b1) $display("FAIL raw_issue id=%0d v=%b exp id=1 v=1", issue.id, issue_valid); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_war_store_lmul();
    req = mk_req(2, LSU, 16, 0, 0, 1, 0, 0, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    // A pending store reads v16 but writes nothing, so a new reader of v16 is free to go.
    req = mk_req(3, VFU, 20, 16, 21, 1, 1, 1, 0, 0, 0);
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL war_store_nowrite got=%b exp=1", req_ready); else pass_cnt++;
    req = mk_req(3, VFU, 18, 4, 8, 1, 1, 1, 0, 0, 2);
    #1;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL war_ready got=%b exp=0", req_ready); else pass_cnt++;
    chk_cnt++; if (hazard !== 1'b1) $display("FAIL war_hazard got=%b exp=1", hazard); else pass_cnt++;
    tick();
    vlsu_rsp.id = 5'd2;
    vlsu_v = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL war_same_cycle got=%b exp=0", req_ready); else pass_cnt++;
    tick();
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL war_released got=%b exp=1", req_ready); else pass_cnt++;
    tick();
    req_valid = 1'b0;
    #1;
    chk_cnt++; if (issue.id !== 5'd3) $display("FAIL war_issue_id got=%0d exp=3", issue.id); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_waw_collision();
    req = mk_req(4, SLD, 10, 0, 11, 1, 0, 1, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    req = mk_req(5, VFU, 10, 12, 0, 1, 1, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL waw_ready got=%b exp=0", req_ready); else pass_cnt++;
    vsldu_rsp.id = 5'd4;
    vsldu_v = 1'b1;
    tick();
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL waw_released got=%b exp=1", req_ready); else pass_cnt++;
    tick();
    req = mk_req(4, VFU, 20, 21, 0, 1, 1, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL waw_reuse_id4 got=%b exp=1", req_ready); else pass_cnt++;
    tick();
    req = mk_req(5, VFU, 24, 25, 0, 1, 1, 0, 0, 0, 0);
    #1;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL coll_ready got=%b exp=0", req_ready); else pass_cnt++;
    chk_cnt++; if (hazard !== 1'b1) $display("FAIL coll_hazard got=%b exp=1", hazard); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_multi_retire();
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = mk_req(i, VFU, 1 + i, 4 + i, 0, 1, 1, 0, 0, 0, 0);
      tick();
    end
    req_valid = 1'b0;
    vfu_rsp.id = 5'd0; vfu_v = 1'b1;
    vlsu_rsp.id = 5'd1; vlsu_v = 1'b1;
    vsldu_rsp.id = 5'd2; vsldu_v = 1'b1;
    tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL multi_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (retire_err !== 1'b0) $display("FAIL multi_err got=%b exp=0", retire_err); else pass_cnt++;
    req = mk_req(3, VFU, 9, 10, 0, 1, 1, 0, 0, 0, 0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    vfu_rsp.id = 5'd3; vfu_v = 1'b1;
    vlsu_rsp.id = 5'd3; vlsu_v = 1'b1;
    tick();
    chk_cnt++; if (retire_err !== 1'b0) $display("FAIL dup_err got=%b exp=0", retire_err); else pass_cnt++;
    vfu_rsp.id = 5'd7; vfu_v = 1'b1;
    tick();
    chk_cnt++; if (retire_err !== 1'b1) $display("FAIL inv_err got=%b exp=1", retire_err); else pass_cnt++;
    repeat (3) tick();
    chk_cnt++; if (retire_err !== 1'b1) $display("FAIL inv_sticky got=%b exp=1", retire_err); else pass_cnt++;
    do_reset();
    chk_cnt++; if (retire_err !== 1'b0) $display("FAIL inv_rst got=%b exp=0", retire_err); else pass_cnt++;
  endtask

  task automatic test_backpressure_con();
    spatz_req_t a;
    spatz_req_t c;
    issue_ready = 1'b0;
    a = mk_req(0, VFU, 1, 2, 3, 1, 1, 1, 0, 0, 0);
    req = a;
    req_valid = 1'b1;
    tick();
    req = mk_req(1, VFU, 4, 5, 6, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready[%0d] got=%b exp=0", i, req_ready); else pass_cnt++;
      chk_cnt++; if (issue !== a || issue_valid !== 1'b1) $display("FAIL bp_hold[%0d] got=%h exp=%h", i, issue, a); else pass_cnt++;
      tick();
    end
    issue_ready = 1'b1;
    tick();
    chk_cnt++; if (issue.id !== 5'd1) $display("FAIL bp_next got=%0d exp=1", issue.id); else pass_cnt++;
    c = mk_req(9, CON, 4, 1, 5, 1, 1, 1, 1, 0, 3);
    req = c;
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL con_ready got=%b exp=1", req_ready); else pass_cnt++;
    chk_cnt++; if (hazard !== 1'b0) $display("FAIL con_hazard got=%b exp=0", hazard); else pass_cnt++;
    tick();
    req_valid = 1'b0;
    #1;
    chk_cnt++; if (issue !== c) $display("FAIL con_issue got=%h exp=%h", issue, c); else pass_cnt++;
    tick();
    vfu_rsp.id = 5'd0; vfu_v = 1'b1;
    vlsu_rsp.id = 5'd1; vlsu_v = 1'b1;
    tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL con_noentry_busy got=%b exp=0", busy); else pass_cnt++;
    vfu_rsp.id = 5'd9; vfu_v = 1'b1;
    tick();
    chk_cnt++; if (retire_err !== 1'b1) $display("FAIL con_noentry_err got=%b exp=1", retire_err); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_random();
    bit exp_ready;
    bit exp_haz;
    bit exp_busy;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req = mk_req($urandom_range(0, 7), ex_unit_e'(2'($urandom_range(0, 3))),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   1'($urandom), $urandom_range(0, 7));
      req_valid = ($urandom_range(0, 3) != 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      vfu_v = ($urandom_range(0, 9) < 4);
      vlsu_v = ($urandom_range(0, 9) < 4);
      vsldu_v = ($urandom_range(0, 9) < 4);
      vfu_rsp.id = (inflight.size() > 0 && $urandom_range(0, 99) != 0) ?
                   instr_id_t'(inflight[$urandom_range(0, inflight.size() - 1)].id) :
                   instr_id_t'($urandom_range(0, 7));
      vlsu_rsp.id = (inflight.size() > 0) ?
                    instr_id_t'(inflight[$urandom_range(0, inflight.size() - 1)].id) : 5'd0;
      vsldu_rsp.id = (inflight.size() > 0) ?
                     instr_id_t'(inflight[$urandom_range(0, inflight.size() - 1)].id) : 5'd0;
      if (inflight.size() == 0) begin
        vlsu_v = 1'b0;
        vsldu_v = 1'b0;
      end
      #1;
      exp_ready = model_ready();
      exp_haz = req_valid && model_blocked(req);
      exp_busy = (inflight.size() > 0) || m_iv;
      chk_cnt++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c=%0d got=%b exp=%b", cyc, req_ready, exp_ready); else pass_cnt++;
      chk_cnt++; if (hazard !== exp_haz) $display("FAIL rnd_hazard c=%0d got=%b exp=%b", cyc, hazard, exp_haz); else pass_cnt++;
      chk_cnt++; if (issue_valid !== m_iv) $display("FAIL rnd_iv c=%0d got=%b exp=%b", cyc, issue_valid, m_iv); else pass_cnt++;
      if (m_iv) begin
        chk_cnt++; if (issue !== m_issue) $display("FAIL rnd_issue c=%0d got=%h exp=%h", cyc, issue, m_issue); else pass_cnt++;
      end
      chk_cnt++; if (busy !== exp_busy) $display("FAIL rnd_busy c=%0d got=%b exp=%b", cyc, busy, exp_busy); else pass_cnt++;
      chk_cnt++; if (retire_err !== m_err) $display("FAIL rnd_err c=%0d got=%b exp=%b", cyc, retire_err, m_err); else pass_cnt++;
      tick();
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_reset_midop();
    test_back_to_back();
    test_raw();
    test_war_store_lmul();
    test_waw_collision();
    test_multi_retire();
    test_backpressure_con();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
